// File: rtl/hv_launch_ctrl.sv
// ---------------------------------------------------------------------------
// hv_launch_ctrl
//
// Operator-facing launch controller that sits directly in front of the HV
// hold timer. It conditions the raw operator inputs, checks the requested
// hold time, and fires a single-cycle launch pulse with a stable delay value.
// It then supervises the hold window and enforces a cooldown and a sticky
// fault lockout.
//
// Build option:
//   HVL_CONFIRM_EN - adds confirm_btn. A start event is then only accepted
//                    while the debounced confirm level is high (two-hand
//                    launch). Without the macro the port does not exist and
//                    a start event alone is enough.
//
// Ports:
//   clk_hvl       in   system clock
//   rst_n_hvl     in   async assert / sync release, active-low reset
//   start_btn     in   raw start pushbutton (async, active-high)
//   arm           in   raw arm key switch (async level)
//   interlock_ok  in   raw interlock chain (async, 1 = safe)
//   confirm_btn   in   raw confirm pushbutton (HVL_CONFIRM_EN only)
//   delay_in[7:0] in   requested hold time in seconds
//   hold_active   in   hold-timer output, already synchronous
//   thhv_launch   out  one-cycle launch pulse to the hold timer
//   delay_out[7:0]out  latched hold time, stable between launches
//   busy          out  high in LAUNCH, HOLD and COOLDOWN
//   fault         out  high in FAULT
//   state_dbg[2:0]out  IDLE=0 ARMED=1 LAUNCH=2 HOLD=3 COOLDOWN=4 FAULT=5
// ---------------------------------------------------------------------------
module hv_launch_ctrl #(
    parameter int CLK_HZ       = 100000000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int COOLDOWN_S   = 2,
    parameter int MAX_DELAY    = 60,
    parameter int ACK_TIMEOUT  = 16
) (
    input  logic       clk_hvl,
    input  logic       rst_n_hvl,
    input  logic       start_btn,
    input  logic       arm,
    input  logic       interlock_ok,
`ifdef HVL_CONFIRM_EN
    input  logic       confirm_btn,
`endif
    input  logic [7:0] delay_in,
    input  logic       hold_active,
    output logic       thhv_launch,
    output logic [7:0] delay_out,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_dbg
);

`ifdef HVL_CONFIRM_EN
    localparam int NUM_IN = 4;
`else
    localparam int NUM_IN = 3;
`endif
    localparam int          DCW     = $clog2(DEBOUNCE_CYC + 1);
    localparam logic [DCW-1:0] DEB_LAST = DCW'(DEBOUNCE_CYC - 1);
    localparam logic [31:0] CD_LAST  = 32'(COOLDOWN_S * CLK_HZ - 1);
    localparam logic [31:0] ACK_LAST = 32'(ACK_TIMEOUT - 1);
    localparam logic [7:0]  MAX_D8   = 8'(MAX_DELAY);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ARMED    = 3'd1,
        S_LAUNCH   = 3'd2,
        S_HOLD     = 3'd3,
        S_COOLDOWN = 3'd4,
        S_FAULT    = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // Input conditioning: one lane per raw input, 2-FF sync then debounce.
    // Lane 0 = start, 1 = arm, 2 = interlock, 3 = confirm (optional).
    // -----------------------------------------------------------------------
    logic [NUM_IN-1:0]          w_raw;
    logic [NUM_IN-1:0][1:0]     r_sync;
    logic [NUM_IN-1:0][DCW-1:0] r_dcnt;
    logic [NUM_IN-1:0]          r_lvl;

    assign w_raw[0] = start_btn;
    assign w_raw[1] = arm;
    assign w_raw[2] = interlock_ok;
`ifdef HVL_CONFIRM_EN
    assign w_raw[3] = confirm_btn;
`endif

    // The debounced level follows the synced input only after it has differed
    // for DEBOUNCE_CYC consecutive cycles; any agreeing cycle restarts it.
    always_ff @(posedge clk_hvl or negedge rst_n_hvl) begin
        if (!rst_n_hvl) begin
            r_sync <= '0;
            r_dcnt <= '0;
            r_lvl  <= '0;
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                r_sync[i] <= {r_sync[i][0], w_raw[i]};
                if (r_sync[i][1] == r_lvl[i]) begin
                    r_dcnt[i] <= '0;
                end else if (r_dcnt[i] == DEB_LAST) begin
                    r_lvl[i]  <= r_sync[i][1];
                    r_dcnt[i] <= '0;
                end else begin
                    r_dcnt[i] <= r_dcnt[i] + 1'b1;
                end
            end
        end
    end

    logic w_start;
    logic w_arm;
    logic w_ilk;
    logic w_confirm;
    logic w_start_evt;
    logic w_delay_ok;
    logic r_start_d;

    assign w_start = r_lvl[0];
    assign w_arm   = r_lvl[1];
    assign w_ilk   = r_lvl[2];
`ifdef HVL_CONFIRM_EN
    assign w_confirm = r_lvl[3];
`else
    assign w_confirm = 1'b1;
`endif

    // Rising edge of the debounced start level: a held button gives one event.
    assign w_start_evt = w_start & ~r_start_d;
    assign w_delay_ok  = (delay_in != 8'd0) && (delay_in <= MAX_D8);

    // -----------------------------------------------------------------------
    // State machine
    // -----------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_latch;
    logic [31:0] r_cnt;   // cycles spent in the current state (HOLD/COOLDOWN)
    logic        r_seen;  // hold_active observed high during this HOLD

    always_ff @(posedge clk_hvl or negedge rst_n_hvl) begin
        if (!rst_n_hvl) r_state <= S_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_arm && w_ilk) w_state_nxt = S_ARMED;
            end
            S_ARMED: begin
                // Interlock is checked first so a simultaneous start never launches.
                if (!w_ilk) begin
                    w_state_nxt = S_FAULT;
                end else if (!w_arm) begin
                    w_state_nxt = S_IDLE;
                end else if (w_start_evt && w_confirm) begin
                    if (w_delay_ok) begin
                        w_state_nxt = S_LAUNCH;
                        w_latch     = 1'b1;
                    end else begin
                        w_state_nxt = S_FAULT;
                    end
                end
            end
            S_LAUNCH: begin
                w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                // The hold timer cannot be aborted; FAULT only flags the event.
                if (!w_ilk) begin
                    w_state_nxt = S_FAULT;
                end else if (r_seen) begin
                    if (!hold_active) w_state_nxt = S_COOLDOWN;
                end else if (!hold_active && (r_cnt >= ACK_LAST)) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_COOLDOWN: begin
                if (!w_ilk) begin
                    w_state_nxt = S_FAULT;
                end else if (r_cnt >= CD_LAST) begin
                    w_state_nxt = w_arm ? S_ARMED : S_IDLE;
                end
            end
            S_FAULT: begin
                if (!w_arm && w_ilk) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Counters, latched delay and registered output decodes. The decodes are
    // taken from the next state so they line up with the state register.
    // -----------------------------------------------------------------------
    logic       r_launch;
    logic       r_busy;
    logic       r_fault;
    logic [7:0] r_delay;

    always_ff @(posedge clk_hvl or negedge rst_n_hvl) begin
        if (!rst_n_hvl) begin
            r_start_d <= 1'b0;
            r_cnt     <= '0;
            r_seen    <= 1'b0;
            r_launch  <= 1'b0;
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
            r_delay   <= '0;
        end else begin
            r_start_d <= w_start;
            if (w_state_nxt != r_state) r_cnt <= '0;
            else if ((r_state == S_HOLD) || (r_state == S_COOLDOWN)) r_cnt <= r_cnt + 32'd1;
            r_seen    <= (r_state == S_HOLD) && (r_seen || hold_active);
            r_launch  <= (w_state_nxt == S_LAUNCH);
            r_busy    <= (w_state_nxt == S_LAUNCH) || (w_state_nxt == S_HOLD) ||
                         (w_state_nxt == S_COOLDOWN);
            r_fault   <= (w_state_nxt == S_FAULT);
            if (w_latch) r_delay <= delay_in;
        end
    end

    assign thhv_launch = r_launch;
    assign delay_out   = r_delay;
    assign busy        = r_busy;
    assign fault       = r_fault;
    assign state_dbg   = r_state;

endmodule

// File: tb/tb_hv_launch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hv_launch_ctrl
//
// Self-checking bench for hv_launch_ctrl with small timing parameters.
// Accepted launches push their expected delay into a scoreboard queue; a
// monitor pops and compares it whenever the DUT issues thhv_launch. A simple
// hold-timer model raises hold_active shortly after each launch.
// ---------------------------------------------------------------------------
module tb_hv_launch_ctrl;
    localparam int CLK_HZ = 10;
    localparam int DEB    = 4;
    localparam int CDS    = 1;
    localparam int MAXD   = 60;
    localparam int ACKT   = 16;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_ARMED = 3'd1, ST_HOLD = 3'd3,
                           ST_COOL = 3'd4, ST_FAULT = 3'd5;

    logic       clk_hvl      = 1'b0;
    logic       rst_n_hvl    = 1'b1;
    logic       start_btn    = 1'b0;
    logic       arm          = 1'b0;
    logic       interlock_ok = 1'b0;
    logic       hold_active  = 1'b0;
    logic [7:0] delay_in     = 8'd0;
`ifdef HVL_CONFIRM_EN
    logic       confirm_btn  = 1'b0;
`endif
    logic       thhv_launch;
    logic [7:0] delay_out;
    logic       busy;
    logic       fault;
    logic [2:0] state_dbg;

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         n_launch = 0;
    bit         model_en = 1'b1;
    logic [7:0] sb_q[$];

    hv_launch_ctrl #(
        .CLK_HZ(CLK_HZ), .DEBOUNCE_CYC(DEB), .COOLDOWN_S(CDS),
        .MAX_DELAY(MAXD), .ACK_TIMEOUT(ACKT)
    ) dut (
        .clk_hvl(clk_hvl), .rst_n_hvl(rst_n_hvl), .start_btn(start_btn),
        .arm(arm), .interlock_ok(interlock_ok),
`ifdef HVL_CONFIRM_EN
        .confirm_btn(confirm_btn),
`endif
        .delay_in(delay_in), .hold_active(hold_active),
        .thhv_launch(thhv_launch), .delay_out(delay_out), .busy(busy),
        .fault(fault), .state_dbg(state_dbg)
    );

    always #5 clk_hvl = ~clk_hvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_hvl);
    endtask

    // Bounded wait for a state; an expired budget shows up as a failed check.
    task automatic wait_st(input logic [2:0] s, input int budget, input string tag,
                           output int n);
        n = 0;
        while (state_dbg !== s && n < budget) begin
            @(negedge clk_hvl);
            n++;
        end
        chk(tag, 32'(state_dbg), 32'(s));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_launch"}, 32'(thhv_launch), 0);
        chk({tag, "_delay"},  32'(delay_out),   0);
        chk({tag, "_busy"},   32'(busy),        0);
        chk({tag, "_fault"},  32'(fault),       0);
        chk({tag, "_state"},  32'(state_dbg),   0);
    endtask

    // Scoreboard consumer: every launch pulse must match a queued delay.
    always @(negedge clk_hvl) begin
        if (rst_n_hvl && thhv_launch === 1'b1) begin
            n_launch++;
            if (sb_q.size() == 0) chk("launch_unexpected", 1, 0);
            else                  chk("launch_delay_out", 32'(delay_out), 32'(sb_q.pop_front()));
        end
    end

    // Hold-timer model: hold_active rises ~2 cycles after launch for 30 cycles.
    initial begin
        forever begin
            @(posedge clk_hvl);
            #1;
            if (model_en && thhv_launch === 1'b1) begin
                @(posedge clk_hvl);
                @(posedge clk_hvl);
                #1 hold_active = 1'b1;
                repeat (30) @(posedge clk_hvl);
                #1 hold_active = 1'b0;
            end
        end
    end

    initial begin
        int n;
        int n0;
        #1 rst_n_hvl = 1'b0;
        cyc(3);
        #2 chk_all_zero("reset");
        cyc(1);
        rst_n_hvl    = 1'b1;
        arm          = 1'b1;
        interlock_ok = 1'b1;
        delay_in     = 8'd3;
`ifdef HVL_CONFIRM_EN
        confirm_btn  = 1'b1;
`endif
        wait_st(ST_ARMED, 30, "armed_after_reset", n);

        // Nominal launch; the button stays held through the whole cycle.
        sb_q.push_back(8'd3);
        start_btn = 1'b1;
        wait_st(ST_HOLD, 30, "nom_hold", n);
        chk("nom_busy", 32'(busy), 1);
        chk("nom_launch_cnt", n_launch, 1);
        wait_st(ST_COOL, 80, "nom_cooldown", n);
        chk("nom_delay_kept", 32'(delay_out), 3);
        wait_st(ST_ARMED, 30, "nom_rearmed", n);
        chk("nom_cooldown_len", n, CLK_HZ * CDS);
        chk("nom_busy_clear", 32'(busy), 0);
        cyc(20);
        start_btn = 1'b0;
        cyc(10);
        chk("nom_no_retrigger", n_launch, 1);

        // Bounce rejection: toggling every 2 cycles never survives the debounce.
        for (int i = 0; i < 10; i++) begin
            start_btn = ~start_btn;
            cyc(2);
        end
        cyc(10);
        chk("bounce_no_launch", n_launch, 1);
        chk("bounce_state", 32'(state_dbg), 32'(ST_ARMED));

        // Invalid delays: 0 and MAX+1 both fault without a pulse.
        for (int k = 0; k < 2; k++) begin
            delay_in  = (k == 0) ? 8'd0 : 8'(MAXD + 1);
            start_btn = 1'b1;
            wait_st(ST_FAULT, 30, "bad_delay_fault", n);
            chk("bad_delay_fault_out", 32'(fault), 1);
            chk("bad_delay_keep", 32'(delay_out), 3);
            start_btn = 1'b0;
            cyc(10);
            chk("bad_delay_sticky", 32'(state_dbg), 32'(ST_FAULT));
            arm = 1'b0;
            wait_st(ST_IDLE, 30, "bad_delay_clear", n);
            chk("bad_delay_fault_clr", 32'(fault), 0);
            arm = 1'b1;
            wait_st(ST_ARMED, 30, "bad_delay_rearm", n);
        end
        chk("bad_delay_no_launch", n_launch, 1);

        // Missing acknowledge at the MAX_DELAY boundary value.
        model_en = 1'b0;
        delay_in = 8'(MAXD);
        sb_q.push_back(8'(MAXD));
        start_btn = 1'b1;
        wait_st(ST_HOLD, 30, "ack_hold", n);
        wait_st(ST_FAULT, 40, "ack_fault", n);
        chk("ack_timeout_len", n, ACKT);
        chk("ack_delay_kept", 32'(delay_out), 32'(MAXD));
        start_btn = 1'b0;
        arm = 1'b0;
        wait_st(ST_IDLE, 30, "ack_clear", n);
        arm = 1'b1;
        model_en = 1'b1;
        wait_st(ST_ARMED, 30, "ack_rearm", n);

        // Interlock drop during HOLD.
        delay_in = 8'd5;
        sb_q.push_back(8'd5);
        start_btn = 1'b1;
        wait_st(ST_HOLD, 30, "ilk_hold", n);
        interlock_ok = 1'b0;
        n = 0;
        while (fault !== 1'b1 && n < 20) begin
            cyc(1);
            n++;
        end
        chk("ilk_fault", 32'(fault), 1);
        chk("ilk_latency_in_window", 32'(n >= 6 && n <= 8), 1);
        chk("ilk_delay_kept", 32'(delay_out), 5);
        start_btn = 1'b0;
        interlock_ok = 1'b1;
        arm = 1'b0;
        cyc(50);
        wait_st(ST_IDLE, 30, "ilk_clear", n);
        arm = 1'b1;
        wait_st(ST_ARMED, 30, "ilk_rearm", n);

`ifdef HVL_CONFIRM_EN
        // Two-hand launch: start without confirm is ignored, not a fault.
        n0 = n_launch;
        confirm_btn = 1'b0;
        cyc(10);
        delay_in  = 8'd4;
        start_btn = 1'b1;
        cyc(15);
        chk("cfm_ignored_state", 32'(state_dbg), 32'(ST_ARMED));
        chk("cfm_ignored_fault", 32'(fault), 0);
        chk("cfm_ignored_launch", n_launch, n0);
        start_btn = 1'b0;
        confirm_btn = 1'b1;
        cyc(10);
        sb_q.push_back(8'd4);
        start_btn = 1'b1;
        wait_st(ST_HOLD, 30, "cfm_hold", n);
        chk("cfm_launch", n_launch, n0 + 1);
        start_btn = 1'b0;
        wait_st(ST_ARMED, 80, "cfm_rearm", n);
`endif

        // Asynchronous reset in the middle of COOLDOWN.
        n0 = n_launch;
        delay_in = 8'd2;
        sb_q.push_back(8'd2);
        start_btn = 1'b1;
        wait_st(ST_COOL, 80, "rst_cooldown", n);
        chk("rst_launch_seen", n_launch, n0 + 1);
        start_btn = 1'b0;
        cyc(3);
        #2 rst_n_hvl = 1'b0;
        #1 chk_all_zero("async_rst");
        cyc(2);
        rst_n_hvl = 1'b1;
        cyc(10);
        chk("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hv_launch_ctrl.md
Name: hv_launch_ctrl

Overview:
- Operator-facing launch controller directly upstream of the HV hold timer (time-of-hold stage).
- Synchronises and debounces the raw start button, arm switch and interlock.
- Validates the requested hold time, then issues a single-cycle launch pulse with a stable delay value.
- Supervises the hold window via the timer's output and enforces a post-hold cooldown and fault lockout.

Parameters:
- CLK_HZ, 100000000, clock cycles per second; sizes the cooldown.
- DEBOUNCE_CYC, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz).
- COOLDOWN_S, 2, seconds of lockout after a hold ends.
- MAX_DELAY, 60, largest accepted hold time in seconds.
- ACK_TIMEOUT, 16, cycles allowed after launch for hold_active to rise.

Ports:
- clk_hvl  in  1  system clock.
- rst_n_hvl  in  1  asynchronous, active-low reset.
- start_btn  in  1  raw start pushbutton, asynchronous, active-high.
- arm  in  1  raw arm key switch, asynchronous, level.
- interlock_ok  in  1  raw interlock chain, asynchronous, 1 = safe.
- delay_in  in  8  requested hold time in seconds.
- hold_active  in  1  hold-timer output (HV held).
- thhv_launch  out  1  one-cycle launch pulse to the hold timer.
- delay_out  out  8  latched hold time to the hold timer.
- busy  out  1  high in LAUNCH, HOLD and COOLDOWN.
- fault  out  1  high in FAULT.
- state_dbg  out  3  encoded state: IDLE=0, ARMED=1, LAUNCH=2, HOLD=3, COOLDOWN=4, FAULT=5.

Behaviour:
- Reset (async assert, sync release) values:
  - thhv_launch=0, delay_out=0, busy=0, fault=0, state=IDLE.
  - All synchroniser and debounced levels reset to 0.
  - All counters reset to 0.
- Input conditioning:
  - start_btn, arm and interlock_ok each pass through a 2-FF synchroniser, then a debouncer.
  - A debounced level changes only after the synced input differs from it for DEBOUNCE_CYC consecutive cycles; any bounce restarts the count.
  - hold_active is synchronous and is not conditioned.
- Start event: 0->1 transition of debounced start; lasts one cycle.
- State machine:
  - IDLE: debounced arm=1 and debounced interlock=1 -> ARMED. Start events are ignored.
  - ARMED:
    - arm=0 -> IDLE.
    - Interlock=0 -> FAULT.
    - Start event with delay_in in 1..MAX_DELAY: latch delay_out <= delay_in, go to LAUNCH.
    - Start event with delay_in = 0 or > MAX_DELAY -> FAULT. delay_out is unchanged.
    - If interlock drops in the same cycle as a start event, FAULT wins and no launch is issued.
  - LAUNCH: thhv_launch=1 for exactly this one cycle, then -> HOLD.
  - HOLD:
    - Wait for hold_active=1; the hold timer raises it 2 cycles after launch.
    - If hold_active is not seen within ACK_TIMEOUT cycles of entering HOLD -> FAULT.
    - After hold_active has been seen high, its fall -> COOLDOWN.
    - Interlock=0 during HOLD -> FAULT immediately. The hold timer has no abort input; fault only flags the condition.
  - COOLDOWN:
    - Count COOLDOWN_S*CLK_HZ cycles (32-bit counter), then go to ARMED if arm=1, otherwise IDLE.
    - Start events are ignored.
    - Interlock=0 -> FAULT.
  - FAULT:
    - Sticky.
    - Exit to IDLE only when debounced arm=0 and debounced interlock=1 at the same time.
    - Start events are ignored.
- delay_out holds its value from latch until the next accepted launch, including through HOLD, COOLDOWN and FAULT. The hold timer compares against it continuously.
- Only one thhv_launch pulse per start event; holding the button never retriggers.
- A button press that completes while the block is not in ARMED is discarded. It is not queued.
- busy and fault are registered decodes of the state register.

Optional Feature:
- Macro: HVL_CONFIRM_EN.
- Defined:
  - Adds input confirm_btn (1 bit, raw, asynchronous), conditioned with the same synchroniser and debouncer as start.
  - In ARMED, a start event is accepted only if debounced confirm=1 in the same cycle (two-hand launch).
  - A start event with confirm=0 is ignored. It does not cause FAULT.
- Not defined: port absent; start event alone suffices.

Test Plan:
Sim parameters: CLK_HZ=10, DEBOUNCE_CYC=4, COOLDOWN_S=1, ACK_TIMEOUT=16.
- Nominal launch: arm=1, interlock=1, delay_in=3, clean start press. Bench model raises hold_active 2 cycles after launch and holds it 30 cycles.
  -> One thhv_launch pulse; delay_out=3; busy high; state goes to COOLDOWN on hold_active fall; ARMED 10 cycles later.
- Bounce rejection: start_btn toggling every 2 cycles for 20 cycles, then low -> no launch, state stays ARMED.
- Invalid delay: delay_in=0 with a start event -> fault=1, no pulse. Repeat with delay_in=61 -> same. Clear with arm=0, interlock=1 -> IDLE.
- Missing acknowledge: launch with hold_active held at 0 -> FAULT exactly 16 cycles after entering HOLD.
- Interlock and reset mid-hold:
  - interlock=0 during HOLD -> fault=1 after 2 sync + 4 debounce cycles; delay_out unchanged.
  - rst_n_hvl=0 mid-COOLDOWN -> all outputs 0 immediately, asynchronously.
- HVL_CONFIRM_EN build: start with confirm=0 -> ignored, no fault. start with confirm=1 -> launch pulse.
